prng_arbiter: RTL
=================

Name: prng_arbiter

Overview:
- Shares one LFSR random-number source between several hardware requesters, e.g. ball spawn logic, colour effects and the game-state FSM.
- Requests are served round-robin. Each draw returns a fresh, decorrelated value through a req/grant/valid handshake.
- Sits beside the ball/colour_mapper datapath in the VGA clock domain. It replaces the direct single-user PRNG hookup.
- Seed comes from board switches via a load strobe.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 10, LFSR and output data width.
- TAPS, 10'h240, Fibonacci feedback mask (bits 9 and 6, i.e. x^10+x^7+1).
- STEPS, 10, LFSR shifts per draw (1..2^8-1).
- SEED_DEFAULT, 10'h2A5, reset value of the LFSR; also substituted for a zero seed.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Seed  in  WIDTH  seed value.
- SeedLoad  in  1  one-cycle strobe to load Seed.
- Req  in  N_REQ  per-requester draw request, level, held until served.
- Gnt  out  N_REQ  one-hot grant, valid for the whole draw.
- Valid  out  1  one-cycle pulse; Data is valid for the Gnt holder.
- Data  out  WIDTH  random value delivered.
- Busy  out  1  high in SHIFT or DELIVER.

Behaviour:
- Reset: Gnt=0, Valid=0, Data=0, Busy=0, lfsr=SEED_DEFAULT, rr_ptr=0, seed_pend=0, state=IDLE.
- LFSR step: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}. It advances only in SHIFT.
- FSM states: IDLE, SHIFT, DELIVER.
- IDLE:
  - If seed_pend or SeedLoad: load Seed (or SEED_DEFAULT if Seed==0), clear seed_pend, and stay in IDLE this cycle. The load has priority over granting.
  - Otherwise, if |Req: grant the first asserted requester at or after rr_ptr (wrap at N_REQ-1 -> 0). Gnt goes one-hot from the next cycle, cnt=STEPS-1, go to SHIFT.
- SHIFT:
  - LFSR shifts every cycle. At cnt==0 go to DELIVER, else cnt--.
  - If the granted Req drops: abort to IDLE. Gnt cleared, no Valid, rr_ptr unchanged, LFSR keeps the shifts already applied.
- DELIVER (one cycle):
  - Valid=1, Data=lfsr, Gnt held.
  - rr_ptr <= granted index+1 (mod N_REQ).
  - Next cycle: IDLE, Gnt=0, Valid=0.
- Data holds its last delivered value until the next DELIVER.
- Latency: Req sampled in IDLE at edge k -> Gnt from k+1 -> Valid at cycle k+STEPS+1. Minimum spacing between consecutive draws is STEPS+2 cycles.
- The requester must hold Req until it sees Valid with its Gnt bit. It may drop Req the cycle after Valid. If Req is still high in IDLE, it becomes a new request, subject to round-robin.
- SeedLoad in SHIFT or DELIVER sets seed_pend. The seed applies at the next IDLE, before any grant. The in-flight draw is unaffected.
- Multiple SeedLoad strobes while pending: the last Seed value wins. Seed is sampled on each strobe into a seed register.
- Reset_n asserted mid-draw: immediate return to reset values, no Valid.
- LFSR never reaches 0: the zero seed is replaced, and a nonzero TAPS with a maximal polynomial is used.

Decomposition:
- Package prng_arb_pkg:
  - state enum {IDLE, SHIFT, DELIVER}.
  - Default WIDTH, TAPS and SEED_DEFAULT constants.
- Sub-module lfsr_core (Clk, Reset_n, load, load_val, step, state out), parameterised by WIDTH/TAPS/SEED_DEFAULT.
- Round-robin pick is a combinational function in the package.

Test Plan:
1. Reset, then release with Req=0 -> Gnt=0, Valid=0, Data=0, Busy=0. Internal lfsr=10'h2A5.
2. SeedLoad with Seed=10'h001, then Req=4'b0001 held -> Gnt=4'b0001 for 11 cycles. Valid pulses at cycle STEPS+1=11 after the sampled request, with Data=10'h009 (sequence 001,002,004,008,010,020,040,081,102,204,009).
3. Req=4'b1111 held continuously after reset -> grants in order 0001,0010,0100,1000,0001. Exactly one Valid per grant, spaced 12 cycles apart.
4. Req=4'b0010, dropped 3 cycles into SHIFT -> no Valid, Gnt=0 next cycle. Subsequent Req=4'b0011 grants index 0 (rr_ptr unchanged at 0).
5. Seed=0 loaded -> lfsr=10'h2A5. SeedLoad with Seed=10'h001 pulsed mid-SHIFT -> current Data is unaffected. The next draw with no further loads returns 10'h009.
6. Reset_n asserted during DELIVER-1 -> no Valid ever issued. All outputs return to reset values asynchronously.

Source files
------------

// File: rtl/prng_arbiter_pkg.sv
// Shared types and helpers for the round-robin PRNG arbiter: FSM states,
// default LFSR constants, the LFSR step and the round-robin pick.
package prng_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DELIVER = 2'd2
    } arb_state_e;

    localparam int         WIDTH_DEF    = 10;
    localparam logic [9:0] TAPS_DEF     = 10'h240;
    localparam logic [9:0] SEED_DEF     = 10'h2A5;
    localparam int         STEPS_DEF    = 10;
    localparam int         MAX_REQ      = 8;

    // One Fibonacci step on a value zero-extended to 16 bits (WIDTH <= 16).
    function automatic logic [15:0] lfsr_adv(input logic [15:0] v,
                                             input logic [15:0] taps,
                                             input int          width);
        logic [15:0] mask;
        mask = 16'((32'h1 << width) - 32'h1);
        return ((v << 1) | {15'b0, ^(v & taps)}) & mask;
    endfunction

    // Returns {found, index} of the first set request at or after ptr.
    function automatic logic [3:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int         n);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        // Walk from the farthest offset down so the nearest hit wins last.
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = 3'((int'(ptr) + i) % n);
                if (req[idx]) res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prng_arbiter_if.sv
// Requester-side handshake and seed bus of the PRNG arbiter.
interface prng_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] Seed;
    logic             SeedLoad;
    logic [N_REQ-1:0] Req;
    logic [N_REQ-1:0] Gnt;
    logic             Valid;
    logic [WIDTH-1:0] Data;
    logic             Busy;

    modport master (output Seed, SeedLoad, Req,
                    input  Gnt, Valid, Data, Busy);
    modport slave  (input  Seed, SeedLoad, Req,
                    output Gnt, Valid, Data, Busy);
endinterface

// File: rtl/prng_arbiter_lfsr_core.sv
// Fibonacci LFSR with synchronous load; a zero load value is replaced by
// the default seed so the register can never lock up at zero.
module lfsr_core
    import prng_arb_pkg::*;
#(
    parameter int               WIDTH        = WIDTH_DEF,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(TAPS_DEF),
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(SEED_DEF)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_val == '0) ? SEED_DEFAULT : load_val;
        end else if (step) begin
            state_d = WIDTH'(lfsr_adv(16'(state_q), 16'(TAPS), WIDTH));
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= SEED_DEFAULT;
        else          state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin arbiter sharing one LFSR between N_REQ requesters; each grant
// runs STEPS shifts and then delivers one value with a single Valid pulse.
module prng_arbiter
    import prng_arb_pkg::*;
#(
    parameter int               N_REQ        = 4,
    parameter int               WIDTH        = WIDTH_DEF,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(TAPS_DEF),
    parameter int               STEPS        = STEPS_DEF,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(SEED_DEF)
) (
    input  logic           Clk,
    input  logic           Reset_n,
    prng_arbiter_if.slave  bus
);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       rr_q, rr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] seed_q, seed_d;

    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] load_val;
    logic             lfsr_load;
    logic             lfsr_step;
    logic [7:0]       req_ext;
    logic [3:0]       pick;

    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .load     (lfsr_load),
        .load_val (load_val),
        .step     (lfsr_step),
        .state    (lfsr)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        seed_d    = bus.SeedLoad ? bus.Seed : seed_q;
        load_val  = bus.SeedLoad ? bus.Seed : seed_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        req_ext              = '0;
        req_ext[N_REQ-1:0]   = bus.Req;
        pick                 = rr_pick(req_ext, rr_q, N_REQ);

        case (state_q)
            IDLE: begin
                if (pend_q || bus.SeedLoad) begin
                    lfsr_load = 1'b1;
                    pend_d    = 1'b0;
                end else if (pick[3]) begin
                    idx_d   = pick[2:0];
                    gnt_d   = N_REQ'(1) << pick[2:0];
                    cnt_d   = 8'(STEPS - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.SeedLoad) pend_d = 1'b1;
                if (!req_ext[idx_q]) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    lfsr_step = 1'b1;
                    if (cnt_q == 8'd0) begin
                        // Register the final shifted value so Data lines up with Valid.
                        data_d  = WIDTH'(lfsr_adv(16'(lfsr), 16'(TAPS), WIDTH));
                        valid_d = 1'b1;
                        state_d = DELIVER;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            DELIVER: begin
                if (bus.SeedLoad) pend_d = 1'b1;
                rr_d    = (idx_q == 3'(N_REQ - 1)) ? 3'd0 : idx_q + 3'd1;
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= 3'd0;
            rr_q    <= 3'd0;
            cnt_q   <= 8'd0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            seed_q  <= seed_d;
        end
    end

    assign bus.Gnt   = gnt_q;
    assign bus.Valid = valid_q;
    assign bus.Data  = data_q;
    assign bus.Busy  = busy_q;

endmodule
